// File: rtl/select12_onehot.sv
// select12_onehot
//   Select unit: finds the set bit of in_mask that has exactly k set bits
//   below it, where k arrives one-hot on in_rank (bit k set means k).
//   The mask is scanned LSB first, one bit per cycle, so a match at bit i
//   terminates early. Valid/ready handshake on both sides; one request in
//   flight at a time, no bypass from output handshake to next accept.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_vld     request valid
//   in_rdy     unit can accept a request (high only in IDLE)
//   in_mask    mask to search
//   in_rank    one-hot rank, WIDTH+1 bits; bit WIDTH is never a legal select
//   out_vld    result valid (high only in DONE)
//   out_rdy    consumer accepts result
//   out_pos    one-hot position of the selected bit, 0 if not found / error
//   out_found  selected bit exists
//   out_err    in_rank was malformed
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; in_rdy=1, result outputs cleared
// SCAN  | walking mask bits LSB first, cnt tracks set bits seen (one-hot)
// DONE  | result presented and held until out_rdy
module select12_onehot #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_mask,
  input  logic [WIDTH:0]   in_rank,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_pos,
  output logic             out_found,
  output logic             out_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    ONE_IDX  = IW'(1);
  localparam logic [WIDTH:0]   ONE_R    = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] ONE_P    = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mask_q, mask_nxt;
  logic [WIDTH:0]   rank_q, rank_nxt;
  logic [WIDTH:0]   cnt_q, cnt_nxt;
  logic [IW-1:0]    idx_q, idx_nxt;
  logic [WIDTH-1:0] pos_q, pos_nxt;
  logic             found_q, found_nxt;
  logic             err_q, err_nxt;
  logic             rank_bad;

  // Zero, multi-hot, or the top bit (k == WIDTH can never select anything).
  assign rank_bad = (in_rank == '0)
                 || ((in_rank & (in_rank - ONE_R)) != '0)
                 || in_rank[WIDTH];

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    rank_nxt  = rank_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    pos_nxt   = pos_q;
    found_nxt = found_q;
    err_nxt   = err_q;

    case (state)
      IDLE: begin
        if (in_vld) begin
          mask_nxt = in_mask;
          rank_nxt = in_rank;
          idx_nxt  = '0;
          cnt_nxt  = ONE_R;
          if (rank_bad) begin
            err_nxt   = 1'b1;
            found_nxt = 1'b0;
            pos_nxt   = '0;
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
          end
        end
      end

      SCAN: begin
        if (mask_q[idx_q] && (cnt_q == rank_q)) begin
          pos_nxt   = ONE_P << idx_q;
          found_nxt = 1'b1;
          err_nxt   = 1'b0;
          state_nxt = DONE;
        end else begin
          // cnt is bounded by 1<<WIDTH because at most WIDTH bits are counted.
          if (mask_q[idx_q]) begin
            cnt_nxt = cnt_q << 1;
          end
          if (idx_q == LAST_IDX) begin
            pos_nxt   = '0;
            found_nxt = 1'b0;
            err_nxt   = 1'b0;
            state_nxt = DONE;
          end else begin
            idx_nxt = idx_q + ONE_IDX;
          end
        end
      end

      DONE: begin
        if (out_rdy) begin
          pos_nxt   = '0;
          found_nxt = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mask_q  <= '0;
      rank_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      mask_q  <= mask_nxt;
      rank_q  <= rank_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      pos_q   <= pos_nxt;
      found_q <= found_nxt;
      err_q   <= err_nxt;
    end
  end

  assign in_rdy    = (state == IDLE);
  assign out_vld   = (state == DONE);
  assign out_pos   = pos_q;
  assign out_found = found_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_select12_onehot.sv
// Bench for select12_onehot: directed cases, back-pressure, mid-scan reset,
// and a randomized sweep. Expected results are pushed to a scoreboard queue
// at accept time; a separate monitor pops and compares when out_vld rises.
//
// Latency is measured in clock edges after the accept edge up to the edge
// that raises out_vld. A malformed rank is decided on the accept edge itself
// (0 extra edges, so out_vld is up for the first cycle after accept); a
// match at bit i needs i+1 further edges; not-found needs WIDTH.
`timescale 1ns/1ps
module tb_select12_onehot;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [W-1:0] in_mask = '0;
  logic [W:0]   in_rank = '0;
  logic         out_vld;
  logic         out_rdy = 1'b1;
  logic [W-1:0] out_pos;
  logic         out_found;
  logic         out_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rdy_rand = 0;

  typedef struct packed {
    logic [11:0] mask;
    logic [7:0]  k;
    logic [11:0] pos;
    logic        found;
    logic        err;
    logic [7:0]  lat;
    logic [31:0] acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   active = 0;
  bit   cur_ok = 0;

  select12_onehot #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_mask(in_mask), .in_rank(in_rank),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pos(out_pos),
    .out_found(out_found), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: list the set-bit positions; the answer is the k-th entry.
  function automatic exp_t model(input logic [11:0] m, input logic [12:0] r);
    exp_t e;
    int   plist[$];
    int   k;
    e = '0;
    e.mask = m;
    k = 0;
    if ($countones(r) != 1 || r[12]) begin
      e.err = 1'b1;
      e.lat = 8'd0;
      return e;
    end
    for (int j = 0; j <= 12; j++) if (r[j]) k = j;
    e.k = 8'(k);
    for (int j = 0; j < 12; j++) if (m[j]) plist.push_back(j);
    if (k < plist.size()) begin
      e.found = 1'b1;
      e.pos   = 12'(1) << plist[k];
      e.lat   = 8'(plist[k] + 1);
    end else begin
      e.lat = 8'd12;
    end
    return e;
  endfunction

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    if (!rst_n || !out_vld) begin
      active = 0;
      cur_ok = 0;
    end else begin
      if (!active) begin
        active = 1;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=out_vld=1 expected=no pending request (t=%0t)", $time);
          cur_ok = 0;
        end else begin
          cur = q.pop_front();
          cur_ok = 1;
          chk("latency", 32'(cyc - int'(cur.acc)), 32'(cur.lat));
        end
      end
      if (cur_ok) begin
        chk("out_pos", 32'(out_pos), 32'(cur.pos));
        chk("out_found", 32'(out_found), 32'(cur.found));
        chk("out_err", 32'(out_err), 32'(cur.err));
        chk("in_rdy_busy", 32'(in_rdy), 32'd0);
        if (out_found === 1'b1) begin
          chk("inv_onehot", 32'($countones(out_pos)), 32'd1);
          chk("inv_in_mask", 32'(|(out_pos & cur.mask)), 32'd1);
          chk("inv_rank", 32'($countones(cur.mask & (out_pos - 12'd1))), 32'(cur.k));
        end
      end
    end
  end

  // Called at a negedge; holds the request until accepted.
  task automatic send(input logic [11:0] m, input logic [12:0] r);
    exp_t e;
    int   b;
    b = 0;
    in_mask = m;
    in_rank = r;
    in_vld  = 1'b1;
    while (!in_rdy && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (!in_rdy) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_rdy=0 expected=in_rdy=1 within 300 cycles");
      in_vld = 1'b0;
      return;
    end
    e = model(m, r);
    e.acc = 32'(cyc + 1);
    q.push_back(e);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (!(in_rdy && !out_vld && q.size() == 0) && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (b >= 300) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=pending=%0d expected=0 within 300 cycles", q.size());
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    logic [11:0] m;
    logic [12:0] r;

    #12;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_out_pos", 32'(out_pos), 32'd0);
    chk("rst_out_found", 32'(out_found), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, consumer always ready.
    send(12'h02C, 13'h0004); wait_idle();
    send(12'h003, 13'h0004); wait_idle();
    send(12'hFFF, 13'h0800); wait_idle();
    send(12'h02C, 13'h0000); wait_idle();
    send(12'h02C, 13'h0006); wait_idle();
    send(12'h02C, 13'h1000); wait_idle();
    send(12'h000, 13'h0001); wait_idle();
    send(12'h001, 13'h0001); wait_idle();

    // Back-pressure: result held, new request refused while DONE.
    out_rdy = 1'b0;
    send(12'h02C, 13'h0001);
    b = 0;
    while (!out_vld && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("bp_out_vld", 32'(out_vld), 32'd1);
    repeat (5) begin
      in_mask = 12'hFFF;
      in_rank = 13'h0001;
      in_vld  = 1'b1;
      chk("bp_in_rdy", 32'(in_rdy), 32'd0);
      chk("bp_out_pos", 32'(out_pos), 32'h004);
      chk("bp_out_vld_hold", 32'(out_vld), 32'd1);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_idle_in_rdy", 32'(in_rdy), 32'd1);
    chk("bp_idle_out_vld", 32'(out_vld), 32'd0);
    chk("bp_idle_out_pos", 32'(out_pos), 32'd0);
    in_vld = 1'b0;
    wait_idle();

    // Reset in the 4th SCAN cycle; the dropped request must never appear.
    send(12'h800, 13'h0001);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_vld", 32'(out_vld), 32'd0);
    chk("arst_in_rdy", 32'(in_rdy), 32'd1);
    chk("arst_out_pos", 32'(out_pos), 32'd0);
    chk("arst_out_found", 32'(out_found), 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      chk("arst_no_output", 32'(out_vld), 32'd0);
    end
    send(12'h02C, 13'h0004); wait_idle();

    // Every rank against a few masks.
    for (int t = 0; t < 4; t++) begin
      m = (t == 0) ? 12'hFFF : 12'($urandom);
      for (int k = 0; k < 12; k++) begin
        r = 13'(1) << k;
        send(m, r);
        wait_idle();
      end
    end

    // Random sweep with random consumer stalls, back-to-back requests.
    rdy_rand = 1;
    for (int n = 0; n < 1000; n++) begin
      m = 12'($urandom);
      if ($urandom_range(0, 9) == 0) r = 13'($urandom);
      else r = 13'(1) << $urandom_range(0, 11);
      send(m, r);
    end
    wait_idle();
    rdy_rand = 0;
    #1;
    out_rdy = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
